branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side consumer of the EX-stage branch decision.
- Predicts taken/target for the fetch PC using a direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.
- Is trained by the resolved outcome that the branch comparator computes in EX (its flag, plus the opcode and target).
- Raises mispredict and redirect_pc so the pipeline can flush IF/ID and refetch.

Parameters:
- ENTRIES, 16, number of BHT/BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- pc_f  in  32  fetch PC
- pred_taken  out  1  prediction for pc_f
- pred_target  out  32  next fetch PC: BTB target if pred_taken, else pc_f+4
- ex_valid  in  1  EX stage holds a live instruction (not bubble/flushed)
- ex_opcode  in  5  instr[6:2] of the EX instruction
- ex_pc  in  32  PC of the EX instruction
- ex_taken  in  1  resolved decision (comparator flag)
- ex_target  in  32  resolved taken target (branch/JAL/JALR address)
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  32  predicted next PC carried down the pipe
- mispredict  out  1  flush request for IF/ID
- redirect_pc  out  32  correct next PC when mispredict=1
- br_count  out  32  resolved control-flow instructions
- mp_count  out  32  mispredicts

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Per entry: valid (1), tag, target (32), ctr (2).
- Lookup is combinational, 0 latency, from pc_f:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : pc_f+4, with 32-bit wrap.
- Control-flow classes:
  - ex_opcode 11000 = conditional branch.
  - 11011 = JAL.
  - 11001 = JALR.
  - Any other opcode, or ex_valid=0: no update, mispredict=0, no counts.
- Actual next PC = ex_taken ? ex_target : ex_pc+4. For JAL/JALR the block treats ex_taken as 1 regardless of the input.
- mispredict (combinational) = control-flow & ex_valid & (ex_pred_target != actual next PC). redirect_pc = actual next PC. This covers a direction miss and a target miss (e.g. JALR).
- Update at the rising edge when control-flow & ex_valid, on the ex_pc entry:
  - Conditional branch, entry hit: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). If taken, target <= ex_target.
  - Conditional branch, entry miss: allocate only if taken. valid=1, tag, target=ex_target, ctr=10. A not-taken miss leaves the entry unchanged.
  - JAL/JALR: allocate/overwrite with valid=1, tag, target=ex_target, ctr=11.
- Counters: br_count +1 per counted instruction; mp_count +1 when mispredict. Both saturate at 0xFFFFFFFF.
- Same-cycle lookup and update on the same index: lookup returns the pre-edge contents. No bypass.
- Reset (rst=0, asynchronous, any time including mid-update): all valid=0, ctr=01, target=0, tag=0, br_count=0, mp_count=0. Combinational outputs follow from the cleared state: pred_taken=0, pred_target=pc_f+4. mispredict is a function of the inputs only and is not forced by reset.
- Aliasing: tag mismatch on a valid entry = miss. Entry is replaced under the allocation rules above.

Decomposition:
- Shared package (riscv_pkg):
  - opcode constants OP_BRANCH=5'b11000, OP_JAL=5'b11011, OP_JALR=5'b11001 (shared with the comparator and control unit).
  - counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - reset counter value WNT.
- One sub-module: bp_table. Holds the storage arrays, the read port (index, returns entry) and the write port (enable, index, entry). Async active-low clear.
- The top level holds classification, counter next-state, mispredict/redirect logic and the statistic counters.

Test Plan:
- Reset, then pc_f=0x100 → pred_taken=0, pred_target=0x104. Cycle with ex_valid=1, opcode 11000, ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_target=0x104 → mispredict=1, redirect_pc=0x80. Next cycle pc_f=0x100 → pred_taken=1 (ctr=10), pred_target=0x80. br_count=1, mp_count=1.
- Same branch resolved not-taken twice → ctr 10→01→00, pred_taken=0. Three more not-taken → stays 00, no underflow. Each carried correct ex_pred_target=0x104 → mispredict=0.
- JALR at ex_pc=0x200, ex_target=0x300, ex_pred_target=0x204 → mispredict=1, redirect 0x300. Repeat with target 0x340 and ex_pred_target=0x300 → target-miss mispredict, redirect 0x340, BTB updated.
- Aliasing, ENTRIES=16: train 0x100 taken, then JAL at 0x140 (same index, different tag) → lookup 0x100 misses (pred_target=0x104), lookup 0x140 hits.
- Lookup pc_f=0x100 in the same cycle as an update to 0x100 → old prediction. New value visible next cycle. Assert rst low mid-sequence → all predictions not-taken and counts 0 immediately.
- ex_valid=0 with opcode 11000, or opcode 01100 with ex_valid=1 → mispredict=0, no table or count change.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode constants, 2-bit predictor counter encoding and its saturating update
//   OP_BRANCH/OP_JAL/OP_JALR : instr[6:2] of control-flow instructions
//   ctr_t                    : SNT/WNT/WT/ST, MSB is the taken prediction
//   CTR_RST                  : counter value after reset
//   sat_ctr                  : saturating +1 (up=1) / -1 (up=0)
package riscv_pkg;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
   localparam ctr_t CTR_RST = WNT;
   function automatic ctr_t sat_ctr(input ctr_t c, input logic up);
      return up ? ((c == ST) ? ST : ctr_t'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
   endfunction
endpackage

// File: rtl/bp_table.sv
// bp_table: BHT/BTB storage, one entry per index (valid, tag, target, ctr)
//   clk, rst (async, active-low clear)
//   f_*  : read port for the fetch lookup (index in, entry out)
//   e_*  : read port for the EX-stage training decision (index in, entry out)
//   wr_* : write port; a write always marks the entry valid
module bp_table
   import riscv_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int IDX_W = $clog2(ENTRIES),
   localparam int TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] f_idx,
   output logic             f_valid,
   output logic [TAG_W-1:0] f_tag,
   output logic [31:0]      f_target,
   output ctr_t             f_ctr,
   input  logic [IDX_W-1:0] e_idx,
   output logic             e_valid,
   output logic [TAG_W-1:0] e_tag,
   output logic [31:0]      e_target,
   output ctr_t             e_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_target,
   input  ctr_t             wr_ctr
);
   logic             valid  [ENTRIES];
   logic [TAG_W-1:0] tag    [ENTRIES];
   logic [31:0]      target [ENTRIES];
   ctr_t             ctr    [ENTRIES];

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= CTR_RST;
         end
      else if (wr_en) begin
         valid[wr_idx]  <= 1'b1;
         tag[wr_idx]    <= wr_tag;
         target[wr_idx] <= wr_target;
         ctr[wr_idx]    <= wr_ctr;
      end

   assign f_valid  = valid[f_idx];
   assign f_tag    = tag[f_idx];
   assign f_target = target[f_idx];
   assign f_ctr    = ctr[f_idx];
   assign e_valid  = valid[e_idx];
   assign e_tag    = tag[e_idx];
   assign e_target = target[e_idx];
   assign e_ctr    = ctr[e_idx];
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT (2-bit counters) + tagged BTB fetch predictor, trained by EX-stage outcomes
//   clk, rst (async, active-low)
//   pc_f -> pred_taken, pred_target        : zero-latency lookup
//   ex_valid/opcode/pc/taken/target        : resolved control-flow instruction
//   ex_pred_taken/ex_pred_target           : prediction carried down with it
//   mispredict, redirect_pc                : flush request and correct next PC
//   br_count, mp_count                     : saturating statistics
module branch_predictor
   import riscv_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [4:0]  ex_opcode,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mp_count
);
   localparam int TAG_W = 30 - IDX_W;

   logic             f_valid, e_valid, f_hit, e_hit;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic [31:0]      f_target, e_target;
   ctr_t             f_ctr, e_ctr, wr_ctr;
   logic             is_br, is_jmp, cf, taken, wr_en;
   logic [31:0]      wr_target;
   logic             unused_pred_taken;

   // the carried target already encodes the carried direction, so only it is compared
   assign unused_pred_taken = ex_pred_taken;

   bp_table #(.ENTRIES(ENTRIES)) u_table (
      .clk       (clk),
      .rst       (rst),
      .f_idx     (pc_f[IDX_W+1:2]),
      .f_valid   (f_valid),
      .f_tag     (f_tag),
      .f_target  (f_target),
      .f_ctr     (f_ctr),
      .e_idx     (ex_pc[IDX_W+1:2]),
      .e_valid   (e_valid),
      .e_tag     (e_tag),
      .e_target  (e_target),
      .e_ctr     (e_ctr),
      .wr_en     (wr_en),
      .wr_idx    (ex_pc[IDX_W+1:2]),
      .wr_tag    (ex_pc[31:IDX_W+2]),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr)
   );

   assign f_hit       = f_valid && (f_tag == pc_f[31:IDX_W+2]);
   assign pred_taken  = f_hit && f_ctr[1];
   assign pred_target = pred_taken ? f_target : pc_f + 32'd4;

   assign is_br       = ex_opcode == OP_BRANCH;
   assign is_jmp      = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
   assign cf          = ex_valid && (is_br || is_jmp);
   assign taken       = is_jmp || ex_taken;
   assign redirect_pc = taken ? ex_target : ex_pc + 32'd4;
   // comparing targets catches both direction misses and indirect-target misses
   assign mispredict  = cf && (ex_pred_target != redirect_pc);

   assign e_hit     = e_valid && (e_tag == ex_pc[31:IDX_W+2]);
   // a not-taken branch that misses must not allocate
   assign wr_en     = cf && (is_jmp || e_hit || ex_taken);
   assign wr_ctr    = is_jmp ? ST : e_hit ? sat_ctr(e_ctr, ex_taken) : WT;
   assign wr_target = (is_br && !ex_taken) ? e_target : ex_target;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         br_count <= '0;
         mp_count <= '0;
      end else begin
         if (cf && !(&br_count)) br_count <= br_count + 32'd1;
         if (mispredict && !(&mp_count)) mp_count <= mp_count + 32'd1;
      end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor (ENTRIES=16)
module tb_branch_predictor;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_f = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid = 1'b0;
   logic [4:0]  ex_opcode = '0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_target = '0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mp_count;

   int n_cmp = 0;
   int n_bad = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_f           (pc_f),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mp_count       (mp_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive one cycle of inputs at the falling edge, then let combinational outputs settle
   task automatic drv(input logic [31:0] pcf, input logic v, input logic [4:0] op, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] ptgt);
      @(negedge clk);
      pc_f           = pcf;
      ex_valid       = v;
      ex_opcode      = op;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_target = ptgt;
      ex_pred_taken  = ptgt != pc + 32'd4;
      #1;
   endtask

   initial begin
      pc_f = 32'h100;
      #1 rst = 1'b0;
      #1;
      chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h104);
      chk("rst_br_count", br_count, 32'd0);
      chk("rst_mp_count", mp_count, 32'd0);
      chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
      #1 rst = 1'b1;

      drv(32'h100, 1, OP_BRANCH, 32'h100, 1, 32'h80, 32'h104);
      chk("br1_mispredict", {31'b0, mispredict}, 32'd1);
      chk("br1_redirect", redirect_pc, 32'h80);
      chk("br1_same_cycle_old", {31'b0, pred_taken}, 32'd0);

      drv(32'h100, 1, OP_BRANCH, 32'h100, 0, 32'h80, 32'h104);
      chk("br1_trained_taken", {31'b0, pred_taken}, 32'd1);
      chk("br1_trained_target", pred_target, 32'h80);
      chk("br1_br_count", br_count, 32'd1);
      chk("br1_mp_count", mp_count, 32'd1);
      chk("nt1_mispredict", {31'b0, mispredict}, 32'd0);

      drv(32'h100, 1, OP_BRANCH, 32'h100, 0, 32'h80, 32'h104);
      chk("nt2_ctr01_taken", {31'b0, pred_taken}, 32'd0);
      chk("nt2_ctr01_target", pred_target, 32'h104);
      chk("nt2_mispredict", {31'b0, mispredict}, 32'd0);

      for (int i = 0; i < 3; i++) begin
         drv(32'h100, 1, OP_BRANCH, 32'h100, 0, 32'h80, 32'h104);
         chk("nt_sat_taken", {31'b0, pred_taken}, 32'd0);
         chk("nt_sat_mispredict", {31'b0, mispredict}, 32'd0);
      end

      drv(32'h100, 1, OP_JALR, 32'h200, 0, 32'h300, 32'h204);
      chk("nt_floor_taken", {31'b0, pred_taken}, 32'd0);
      chk("jalr1_mispredict", {31'b0, mispredict}, 32'd1);
      chk("jalr1_redirect", redirect_pc, 32'h300);
      chk("jalr1_br_count", br_count, 32'd6);
      chk("jalr1_mp_count", mp_count, 32'd1);

      drv(32'h200, 1, OP_JALR, 32'h200, 0, 32'h340, 32'h300);
      chk("jalr1_pred_taken", {31'b0, pred_taken}, 32'd1);
      chk("jalr1_pred_target", pred_target, 32'h300);
      chk("jalr2_mispredict", {31'b0, mispredict}, 32'd1);
      chk("jalr2_redirect", redirect_pc, 32'h340);

      drv(32'h200, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
      chk("jalr2_pred_target", pred_target, 32'h340);
      chk("jalr2_br_count", br_count, 32'd8);
      chk("jalr2_mp_count", mp_count, 32'd3);

      drv(32'h100, 1, OP_BRANCH, 32'h100, 1, 32'h80, 32'h104);
      chk("alias_jalr_miss_taken", {31'b0, pred_taken}, 32'd0);
      chk("alias_jalr_miss_target", pred_target, 32'h104);
      chk("br_realloc_mispredict", {31'b0, mispredict}, 32'd1);

      drv(32'h100, 1, OP_JAL, 32'h140, 0, 32'h500, 32'h144);
      chk("realloc_taken", {31'b0, pred_taken}, 32'd1);
      chk("realloc_target", pred_target, 32'h80);
      chk("jal_mispredict", {31'b0, mispredict}, 32'd1);
      chk("jal_redirect", redirect_pc, 32'h500);

      drv(32'h100, 0, OP_BRANCH, 32'h140, 1, 32'h999, 32'h0);
      chk("alias_100_miss_taken", {31'b0, pred_taken}, 32'd0);
      chk("alias_100_miss_target", pred_target, 32'h104);
      chk("invalid_no_mispredict", {31'b0, mispredict}, 32'd0);

      drv(32'h140, 1, 5'b01100, 32'h140, 1, 32'h999, 32'h0);
      chk("alias_140_hit_taken", {31'b0, pred_taken}, 32'd1);
      chk("alias_140_hit_target", pred_target, 32'h500);
      chk("alu_no_mispredict", {31'b0, mispredict}, 32'd0);
      chk("invalid_br_count", br_count, 32'd10);
      chk("invalid_mp_count", mp_count, 32'd5);

      drv(32'h140, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
      chk("alu_table_kept", pred_target, 32'h500);
      chk("alu_br_count", br_count, 32'd10);
      chk("alu_mp_count", mp_count, 32'd5);

      drv(32'h140, 1, OP_JAL, 32'h140, 1, 32'h600, 32'h144);
      #2 rst = 1'b0;
      #1;
      chk("midrst_pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("midrst_pred_target", pred_target, 32'h144);
      chk("midrst_br_count", br_count, 32'd0);
      chk("midrst_mp_count", mp_count, 32'd0);
      chk("midrst_mispredict_inputs", {31'b0, mispredict}, 32'd1);
      @(posedge clk);
      #1;
      chk("midrst_held_taken", {31'b0, pred_taken}, 32'd0);
      chk("midrst_held_br_count", br_count, 32'd0);
      rst = 1'b1;
      drv(32'h140, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
      chk("postrst_pred_taken", {31'b0, pred_taken}, 32'd0);
      chk("postrst_pred_target", pred_target, 32'h144);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
